// File: rtl/reg_op_sequencer.sv
`default_nettype none
// reg_op_sequencer -- IDLE/READ/EXEC/WRITE sequencer running one ALU op against an external register file.
// Rev 1.0 -- optional macro OVERFLOW_FLAG_EN adds a registered signed-overflow output for ADD/SUB.
module reg_op_sequencer #(
  parameter int num_bit_of_data   = 32,
  parameter int num_bit_of_column = 2
) (
  input  logic                         CLK,
  input  logic                         RST_n,
  input  logic                         Start,
  input  logic [2:0]                   Op,
  input  logic [num_bit_of_column-1:0] Src1,
  input  logic [num_bit_of_column-1:0] Src2,
  input  logic [num_bit_of_column-1:0] Dst,
  output logic                         Busy,
  output logic                         Done,
  output logic [num_bit_of_data-1:0]   Result,
  output logic                         Zero,
  output logic [num_bit_of_column-1:0] Out_Addr1,
  output logic [num_bit_of_column-1:0] Out_Addr2,
  input  logic [num_bit_of_data-1:0]   Data_out1,
  input  logic [num_bit_of_data-1:0]   Data_out2,
  output logic                         WE,
  output logic [num_bit_of_column-1:0] In_Addr,
  output logic [num_bit_of_data-1:0]   Data_in
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic                         Overflow
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  localparam int SHAMT_W = (num_bit_of_data > 1) ? $clog2(num_bit_of_data) : 1;

  logic [1:0]                   state;
  logic [1:0]                   next_state;
  logic [2:0]                   op_reg;
  logic [num_bit_of_column-1:0] dst_reg;
  logic [num_bit_of_data-1:0]   opnd_a;
  logic [num_bit_of_data-1:0]   opnd_b;
  logic [num_bit_of_data-1:0]   alu_result;
  logic                         is_nop;

  assign is_nop = (op_reg == OP_NOP);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (Start) next_state = READ;
      READ:    next_state = EXEC;
      EXEC:    next_state = WRITE;
      WRITE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state != IDLE);
    WE   = (state == WRITE) && !is_nop;
  end

  always_comb begin
    alu_result = '0;
    case (op_reg)
      OP_ADD:  alu_result = opnd_a + opnd_b;
      OP_SUB:  alu_result = opnd_a - opnd_b;
      OP_AND:  alu_result = opnd_a & opnd_b;
      OP_OR:   alu_result = opnd_a | opnd_b;
      OP_XOR:  alu_result = opnd_a ^ opnd_b;
      OP_SLT:  alu_result = {{(num_bit_of_data-1){1'b0}}, ($signed(opnd_a) < $signed(opnd_b))};
      OP_SHL:  alu_result = opnd_a << opnd_b[SHAMT_W-1:0];
      default: alu_result = '0;
    endcase
  end

  // Read addresses are the captured sources themselves, so they stay put outside READ.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      op_reg    <= '0;
      dst_reg   <= '0;
      Out_Addr1 <= '0;
      Out_Addr2 <= '0;
      opnd_a    <= '0;
      opnd_b    <= '0;
      Result    <= '0;
      Zero      <= 1'b1;
      In_Addr   <= '0;
      Data_in   <= '0;
      Done      <= 1'b0;
    end else begin
      Done <= (state == WRITE);
      case (state)
        IDLE: begin
          if (Start) begin
            op_reg    <= Op;
            dst_reg   <= Dst;
            Out_Addr1 <= Src1;
            Out_Addr2 <= Src2;
          end
        end
        READ: begin
          opnd_a <= Data_out1;
          opnd_b <= Data_out2;
        end
        EXEC: begin
          if (!is_nop) begin
            Result  <= alu_result;
            Zero    <= (alu_result == '0);
            In_Addr <= dst_reg;
            Data_in <= alu_result;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef OVERFLOW_FLAG_EN
  localparam int MSB = num_bit_of_data - 1;

  logic ovf_next;

  always_comb begin
    ovf_next = 1'b0;
    case (op_reg)
      OP_ADD:  ovf_next = (opnd_a[MSB] == opnd_b[MSB]) && (alu_result[MSB] != opnd_a[MSB]);
      OP_SUB:  ovf_next = (opnd_a[MSB] != opnd_b[MSB]) && (alu_result[MSB] != opnd_a[MSB]);
      default: ovf_next = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      Overflow <= 1'b0;
    end else if ((state == EXEC) && !is_nop) begin
      Overflow <= ovf_next;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_op_sequencer.sv
`default_nettype none
// tb_reg_op_sequencer -- directed vectors against a bench register file, checked each cycle against a timeline model.
module tb_reg_op_sequencer;

  localparam int DW = 32;
  localparam int AW = 2;

  logic          CLK   = 1'b0;
  logic          RST_n = 1'b0;
  logic          Start = 1'b0;
  logic [2:0]    Op    = 3'd0;
  logic [AW-1:0] Src1  = '0;
  logic [AW-1:0] Src2  = '0;
  logic [AW-1:0] Dst   = '0;
  logic          Busy, Done, WE, Zero;
  logic [DW-1:0] Result, Data_in, Data_out1, Data_out2;
  logic [AW-1:0] Out_Addr1, Out_Addr2, In_Addr;
`ifdef OVERFLOW_FLAG_EN
  logic          Overflow;
`endif

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  logic [DW-1:0] rf[4];
  logic [DW-1:0] rf_init[4];
  logic          rf_load = 1'b0;

  always #5 CLK = ~CLK;

  reg_op_sequencer #(.num_bit_of_data(DW), .num_bit_of_column(AW)) dut (
    .CLK(CLK), .RST_n(RST_n), .Start(Start), .Op(Op),
    .Src1(Src1), .Src2(Src2), .Dst(Dst),
    .Busy(Busy), .Done(Done), .Result(Result), .Zero(Zero),
    .Out_Addr1(Out_Addr1), .Out_Addr2(Out_Addr2),
    .Data_out1(Data_out1), .Data_out2(Data_out2),
    .WE(WE), .In_Addr(In_Addr), .Data_in(Data_in)
`ifdef OVERFLOW_FLAG_EN
    , .Overflow(Overflow)
`endif
  );

  // Register file: combinational read, write on WE at the rising edge.
  assign Data_out1 = rf[Out_Addr1];
  assign Data_out2 = rf[Out_Addr2];

  always @(posedge CLK) begin
    if (rf_load) begin
      for (int i = 0; i < 4; i++) rf[i] <= rf_init[i];
    end else if (WE) begin
      rf[In_Addr] <= Data_in;
    end
  end

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
      3'd6:    return a << (b % 32);
      default: return 32'd0;
    endcase
  endfunction

`ifdef OVERFLOW_FLAG_EN
  function automatic logic ref_ovf(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    if (op == 3'd0)      r = sa + sb;
    else if (op == 3'd1) r = sa - sb;
    else                 return 1'b0;
    return (r > longint'(2147483647)) || (r < -longint'(2147483647) - 1);
  endfunction
`endif

  // Model: m_age counts cycles since an op was accepted (0 = idle); write lands three edges later.
  int          m_age;
  logic        m_done, m_zero;
  logic [2:0]  m_op;
  logic [1:0]  m_s1, m_s2, m_dst, m_inaddr;
  logic [31:0] m_res, m_datain, m_v;
  logic [31:0] m_rf[4];
`ifdef OVERFLOW_FLAG_EN
  logic        m_ovf;
`endif

  assign m_v = ref_alu(m_op, m_rf[m_s1], m_rf[m_s2]);

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      m_age    <= 0;
      m_done   <= 1'b0;
      m_res    <= 32'd0;
      m_zero   <= 1'b1;
      m_op     <= 3'd0;
      m_s1     <= 2'd0;
      m_s2     <= 2'd0;
      m_dst    <= 2'd0;
      m_inaddr <= 2'd0;
      m_datain <= 32'd0;
`ifdef OVERFLOW_FLAG_EN
      m_ovf    <= 1'b0;
`endif
    end else begin
      m_done <= (m_age == 3);
      if (rf_load) m_rf <= rf_init;
      if (m_age == 0) begin
        if (Start) begin
          m_age <= 1;
          m_op  <= Op;
          m_s1  <= Src1;
          m_s2  <= Src2;
          m_dst <= Dst;
        end
      end else if (m_age == 1) begin
        m_age <= 2;
      end else if (m_age == 2) begin
        m_age <= 3;
        if (m_op != 3'b111) begin
          m_res    <= m_v;
          m_zero   <= (m_v == 32'd0);
          m_inaddr <= m_dst;
          m_datain <= m_v;
`ifdef OVERFLOW_FLAG_EN
          m_ovf    <= ref_ovf(m_op, m_rf[m_s1], m_rf[m_s2]);
`endif
        end
      end else begin
        m_age <= 0;
        if (m_op != 3'b111) m_rf[m_dst] <= m_datain;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("busy",      32'(Busy),      32'(m_age != 0));
      chk("we",        32'(WE),        32'((m_age == 3) && (m_op != 3'b111)));
      chk("done",      32'(Done),      32'(m_done));
      chk("result",    Result,         m_res);
      chk("zero",      32'(Zero),      32'(m_zero));
      chk("out_addr1", 32'(Out_Addr1), 32'(m_s1));
      chk("out_addr2", 32'(Out_Addr2), 32'(m_s2));
      chk("in_addr",   32'(In_Addr),   32'(m_inaddr));
      chk("data_in",   Data_in,        m_datain);
`ifdef OVERFLOW_FLAG_EN
      chk("overflow",  32'(Overflow),  32'(m_ovf));
`endif
    end
  end

  task automatic load_rf(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] v3);
    @(negedge CLK);
    rf_init[0] = v0;
    rf_init[1] = v1;
    rf_init[2] = v2;
    rf_init[3] = v3;
    rf_load    = 1'b1;
    @(negedge CLK);
    rf_load    = 1'b0;
  endtask

  // One Start pulse, then eight observed cycles; records write activity and when Done appeared.
  task automatic run_op(input logic [2:0] op, input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] d,
                        output int we_cnt, output logic [31:0] wa, output logic [31:0] wd,
                        output int done_at, output int done_cnt);
    we_cnt = 0; wa = 32'd0; wd = 32'd0; done_at = -1; done_cnt = 0;
    @(negedge CLK);
    Start = 1'b1; Op = op; Src1 = s1; Src2 = s2; Dst = d;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      if (k == 1) Start = 1'b0;
      if (WE) begin
        we_cnt++;
        wa = 32'(In_Addr);
        wd = Data_in;
      end
      if (Done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
    end
  endtask

  logic [2:0]  t_op [7] = '{3'd6, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd0};
  logic [1:0]  t_s1 [7] = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd2};
  logic [1:0]  t_s2 [7] = '{2'd3, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
  logic [1:0]  t_d  [7] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd2};
  logic [31:0] t_exp[7] = '{32'h7F8007F8, 32'h00F00034, 32'hFFF012FF, 32'hFF0012CB,
                            32'h00000001, 32'h00000000, 32'h00000000};

  initial begin
    int          we_cnt, done_at, done_cnt, dones;
    logic [31:0] wa, wd;

    RST_n = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy",    32'(Busy),      32'd0);
    chk("rst_done",    32'(Done),      32'd0);
    chk("rst_we",      32'(WE),        32'd0);
    chk("rst_result",  Result,         32'd0);
    chk("rst_zero",    32'(Zero),      32'd1);
    chk("rst_addr1",   32'(Out_Addr1), 32'd0);
    chk("rst_in_addr", 32'(In_Addr),   32'd0);
    chk("rst_data_in", Data_in,        32'd0);
    @(negedge CLK);
    RST_n  = 1'b1;
    cmp_en = 1'b1;

    load_rf(32'd0, 32'd5, 32'd3, 32'd0);
    run_op(3'b000, 2'd1, 2'd2, 2'd3, we_cnt, wa, wd, done_at, done_cnt);
    chk("add_we_cnt",  32'(we_cnt),  32'd1);
    chk("add_in_addr", wa,           32'd3);
    chk("add_data_in", wd,           32'd8);
    chk("add_done_at", 32'(done_at), 32'd4);
    chk("add_zero",    32'(Zero),    32'd0);
    chk("add_rf3",     rf[3],        32'd8);

    run_op(3'b111, 2'd1, 2'd2, 2'd0, we_cnt, wa, wd, done_at, done_cnt);
    chk("nop_we_cnt",   32'(we_cnt),   32'd0);
    chk("nop_done_cnt", 32'(done_cnt), 32'd1);
    chk("nop_result",   Result,        32'd8);

    run_op(3'b001, 2'd2, 2'd1, 2'd0, we_cnt, wa, wd, done_at, done_cnt);
    chk("sub_data_in", wd, 32'hFFFFFFFE);
    chk("sub_in_addr", wa, 32'd0);
    run_op(3'b101, 2'd2, 2'd1, 2'd0, we_cnt, wa, wd, done_at, done_cnt);
    chk("slt_data_in", wd, 32'd1);

    load_rf(32'hF0F01234, 32'h0FF000FF, 32'h80000000, 32'h00000023);
    for (int i = 0; i < 7; i++) begin
      run_op(t_op[i], t_s1[i], t_s2[i], t_d[i], we_cnt, wa, wd, done_at, done_cnt);
      chk($sformatf("tbl%0d_data_in", i), wd,         t_exp[i]);
      chk($sformatf("tbl%0d_zero", i),    32'(Zero),  32'(t_exp[i] == 32'd0));
    end

    // Start held high: inputs change every cycle, only the ones present at acceptance matter.
    dones = 0;
    @(negedge CLK);
    Start = 1'b1; Op = 3'd0; Src1 = 2'd1; Src2 = 2'd2; Dst = 2'd0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      if (Done) dones++;
      if (k < 16) begin
        Op  = (k % 3 == 0) ? 3'd0 : ((k % 3 == 1) ? 3'd4 : 3'd3);
        Dst = (k % 3 == 0) ? 2'd0 : 2'd3;
      end else begin
        Start = 1'b0;
      end
    end
    chk("b2b_done_cnt", 32'(dones), 32'd4);

    // Reset asserted mid-EXEC must abort with no write.
    load_rf(32'd0, 32'd5, 32'd3, 32'd0);
    @(negedge CLK);
    Start = 1'b1; Op = 3'd0; Src1 = 2'd1; Src2 = 2'd2; Dst = 2'd0;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    @(posedge CLK);
    #2 RST_n = 1'b0;
    #1;
    chk("abort_busy",   32'(Busy),      32'd0);
    chk("abort_we",     32'(WE),        32'd0);
    chk("abort_done",   32'(Done),      32'd0);
    chk("abort_result", Result,         32'd0);
    chk("abort_zero",   32'(Zero),      32'd1);
    chk("abort_addr1",  32'(Out_Addr1), 32'd1 - 32'd1);
    @(posedge CLK);
    #2 RST_n = 1'b1;
    repeat (6) @(negedge CLK);
    chk("abort_rf0", rf[0], 32'd0);

    run_op(3'b000, 2'd1, 2'd2, 2'd3, we_cnt, wa, wd, done_at, done_cnt);
    chk("recover_data_in", wd, 32'd8);

`ifdef OVERFLOW_FLAG_EN
    load_rf(32'd0, 32'h7FFFFFFF, 32'd1, 32'd0);
    run_op(3'b000, 2'd1, 2'd2, 2'd0, we_cnt, wa, wd, done_at, done_cnt);
    chk("ovf_data_in", wd,             32'h80000000);
    chk("ovf_flag",    32'(Overflow),  32'd1);
`endif

    repeat (2) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/reg_op_sequencer.md
REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

Interface
REQ-001 The block SHALL have parameter num_bit_of_data, default 32, meaning operand/result width.
REQ-002 The block SHALL have parameter num_bit_of_column, default 2, meaning register address width.
REQ-003 The block SHALL have ports:
- CLK  input  1  clock, all state on rising edge.
- RST_n  input  1  asynchronous active-low reset.
- Start  input  1  request to execute one operation.
- Op  input  3  operation code.
- Src1, Src2  input  num_bit_of_column  operand register addresses.
- Dst  input  num_bit_of_column  destination register address.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle completion pulse.
- Result  output  num_bit_of_data  last computed result.
- Zero  output  1  Result equals 0.
- Out_Addr1, Out_Addr2  output  num_bit_of_column  register file read addresses.
- Data_out1, Data_out2  input  num_bit_of_data  register file read data, combinational from Out_Addr1/2.
- WE  output  1  register file write enable.
- In_Addr  output  num_bit_of_column  register file write address.
- Data_in  output  num_bit_of_data  register file write data.
REQ-004 Clock is CLK only; reset is RST_n, asynchronous, active-low.

Function
REQ-005 FSM states SHALL be IDLE, READ, EXEC, WRITE; encoding free.
REQ-006 IDLE: on Start=1 at a rising edge, Op/Src1/Src2/Dst SHALL be captured and state -> READ; Start=0 stays IDLE.
REQ-007 READ: Out_Addr1=captured Src1, Out_Addr2=captured Src2; at next edge Data_out1/2 SHALL be latched as operands A/B; -> EXEC.
REQ-008 EXEC: at next edge Result and Zero SHALL be registered from A op B; -> WRITE.
REQ-009 WRITE: WE=1, In_Addr=captured Dst, Data_in=Result for exactly one cycle (Op!=111); at next edge -> IDLE with Done=1 for that one following cycle.
REQ-010 Latency: Start sampled at edge n -> write at edge n+3 -> Done high during cycle after edge n+3.
REQ-011 Busy SHALL be 1 in READ, EXEC, WRITE and 0 in IDLE.
REQ-012 Start while Busy=1 SHALL be ignored; Start in the Done cycle (IDLE) SHALL be accepted normally.
REQ-013 Ops: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SLT (signed, result 1 or 0), 110 SHL (A << B[$clog2(num_bit_of_data)-1:0]), 111 NOP.
REQ-014 ADD/SUB SHALL wrap modulo 2^num_bit_of_data.
REQ-015 NOP SHALL traverse all states, keep WE=0, leave Result/Zero unchanged, still pulse Done.
REQ-016 Dst equal to Src1 or Src2 is legal; operands are the pre-write values.
REQ-017 WE SHALL be 0 in every state except WRITE; In_Addr/Data_in hold last values when WE=0.
REQ-018 Out_Addr1/2 SHALL hold captured Src1/Src2 outside READ.

Reset
REQ-019 RST_n=0 SHALL immediately force IDLE, Busy=0, Done=0, WE=0, Result=0, Zero=1, all address/data outputs 0.
REQ-020 Reset during any state SHALL abort the operation with no register file write and no Done pulse.

Configuration
REQ-021 Macro OVERFLOW_FLAG_EN defined: extra output Overflow (1 bit), registered in EXEC, 1 on signed overflow of ADD/SUB, 0 for other ops, unchanged on NOP, reset 0.
REQ-022 OVERFLOW_FLAG_EN undefined: no Overflow port; all other behaviour identical.

Verification
REQ-023 Bench register file model R0=0, R1=5, R2=3, R3=0; Start, Op=000, Src1=1, Src2=2, Dst=3 -> WE one cycle with In_Addr=3, Data_in=8; Done 4 cycles after Start; Zero=0.
REQ-024 Op=001, Src1=2, Src2=1, Dst=0 -> Data_in=32'hFFFFFFFE; SLT same operands -> Data_in=1.
REQ-025 Op=111 after REQ-023 -> WE never 1, Result stays 8, Done pulses once.
REQ-026 Start held high continuously -> operations back-to-back, one every 4 cycles, extra Start pulses while Busy ignored.
REQ-027 RST_n low during EXEC -> WE stays 0, Busy/Done 0, Result=0, Zero=1 same cycle.
REQ-028 With OVERFLOW_FLAG_EN, R1=32'h7FFFFFFF, R2=1, ADD -> Data_in=32'h80000000, Overflow=1.
